// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: Moore FSM driving datapath enables,
// memory handshake stalls, illegal-op flag and retired-instruction counter.
module multicycle_control_unit #(
    parameter bit EN_ADDI       = 1'b1,
    parameter bit EN_JUMP       = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_control,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nx;
    logic   ill_nx;
    logic   mr;

    logic   is_lw, is_sw, is_mem, is_r, is_beq, is_addi, is_j;
    logic   fn_ok;
    logic [2:0] fn_alu;

    logic   pc_en_w, mem_write_w, ir_write_w, reg_write_w, done_w;

    assign mr = MEM_HANDSHAKE ? mem_ready : 1'b1;

    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_mem  = is_lw | is_sw;
    assign is_r    = (opcode == OP_R);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_addi = EN_ADDI && (opcode == OP_ADDI);
    assign is_j    = EN_JUMP && (opcode == OP_J);

    always_comb begin
        fn_ok  = 1'b1;
        fn_alu = 3'b010;
        unique case (funct)
            6'b100000: fn_alu = 3'b010;
            6'b100010: fn_alu = 3'b110;
            6'b100100: fn_alu = 3'b000;
            6'b100101: fn_alu = 3'b001;
            6'b101010: fn_alu = 3'b111;
            default: begin
                fn_alu = 3'b010;
                fn_ok  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nx = S_FETCH;
        ill_nx   = 1'b0;
        case (state)
            S_FETCH:  state_nx = mr ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:  state_nx = S_MEMADR;
                    is_r:    state_nx = S_EXEC;
                    is_beq:  state_nx = S_BRANCH;
                    is_addi: state_nx = S_ADDIEX;
                    is_j:    state_nx = S_JUMP;
                    default: ill_nx   = 1'b1;
                endcase
            end
            S_MEMADR: begin
                if (is_lw)
                    state_nx = S_MEMRD;
                else if (is_sw)
                    state_nx = S_MEMWR;
            end
            S_MEMRD:  state_nx = mr ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nx = mr ? S_FETCH : S_MEMWR;
            S_EXEC: begin
                state_nx = fn_ok ? S_ALUWB : S_FETCH;
                ill_nx   = ~fn_ok;
            end
            S_ADDIEX: state_nx = S_ADDIWB;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        pc_en_w     = 1'b0;
        iord        = 1'b0;
        mem_write_w = 1'b0;
        ir_write_w  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_w = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = 3'b010;
        done_w      = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                ir_write_w = mr;
                pc_en_w    = mr;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_w = 1'b1;
                done_w      = 1'b1;
            end
            // strobe held until memory accepts; retire on acceptance
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_w = 1'b1;
                done_w      = mr;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = fn_alu;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_w = 1'b1;
                done_w      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pc_en_w     = zero;
                done_w      = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_w = 1'b1;
                done_w      = 1'b1;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en_w = 1'b1;
                done_w  = 1'b1;
            end
            default: ;
        endcase
    end

    // enables are killed while reset is held, independent of the clock
    assign pc_en      = pc_en_w & rst_n;
    assign mem_write  = mem_write_w & rst_n;
    assign ir_write   = ir_write_w & rst_n;
    assign reg_write  = reg_write_w & rst_n;
    assign instr_done = done_w & rst_n;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            illegal_op  <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state      <= state_nx;
            illegal_op <= ill_nx;
            if (done_w)
                retired_cnt <= retired_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against an
// instruction-level expected-trace model.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] op1, fn1, op2, fn2;
    logic z1, mr1, z2, mr2;

    logic pe1, io1, mw1, iw1, rd1, m2r1, rw1, asa1, il1, dn1;
    logic [1:0] asb1, ps1;
    logic [2:0] alu1;
    logic [15:0] cnt1;
    logic [3:0] st1;

    logic pe2, io2, mw2, iw2, rd2, m2r2, rw2, asa2, il2, dn2;
    logic [1:0] asb2, ps2;
    logic [2:0] alu2;
    logic [3:0] cnt2;
    logic [3:0] st2;

    multicycle_control_unit dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(op1), .funct(fn1),
        .zero(z1), .mem_ready(mr1), .pc_en(pe1), .iord(io1),
        .mem_write(mw1), .ir_write(iw1), .reg_dst(rd1),
        .mem_to_reg(m2r1), .reg_write(rw1), .alu_src_a(asa1),
        .alu_src_b(asb1), .pc_src(ps1), .alu_control(alu1),
        .illegal_op(il1), .instr_done(dn1), .retired_cnt(cnt1),
        .state_dbg(st1)
    );

    multicycle_control_unit #(
        .EN_ADDI(1'b0), .EN_JUMP(1'b1),
        .MEM_HANDSHAKE(1'b0), .CNT_W(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(op2), .funct(fn2),
        .zero(z2), .mem_ready(mr2), .pc_en(pe2), .iord(io2),
        .mem_write(mw2), .ir_write(iw2), .reg_dst(rd2),
        .mem_to_reg(m2r2), .reg_write(rw2), .alu_src_a(asa2),
        .alu_src_b(asb2), .pc_src(ps2), .alu_control(alu2),
        .illegal_op(il2), .instr_done(dn2), .retired_cnt(cnt2),
        .state_dbg(st2)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int st;
        bit mr;
        bit irw, pcen, regw, memw, done;
        int alu;
    } cyc_t;

    cyc_t q[$];
    int cnt_m[2];
    bit pend[2];

    function automatic void push(int st, bit mr, bit irw, bit pcen,
                                 bit regw, bit memw, bit done, int alu);
        cyc_t c;
        c.st = st; c.mr = mr; c.irw = irw; c.pcen = pcen;
        c.regw = regw; c.memw = memw; c.done = done; c.alu = alu;
        q.push_back(c);
    endfunction

    function automatic int alu_of(logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    // {mask,value} over {iord,reg_dst,mem_to_reg,asa,asb[1:0],pcsrc[1:0]}
    function automatic logic [15:0] mux_exp(int st);
        case (st)
            0:  return {8'b1001_1111, 8'b0000_0100};
            1:  return {8'b0001_1100, 8'b0000_1100};
            2:  return {8'b0001_1100, 8'b0001_1000};
            3:  return {8'b1000_0000, 8'b1000_0000};
            4:  return {8'b0110_0000, 8'b0010_0000};
            5:  return {8'b1000_0000, 8'b1000_0000};
            6:  return {8'b0001_1100, 8'b0001_0000};
            7:  return {8'b0110_0000, 8'b0100_0000};
            8:  return {8'b0001_1111, 8'b0001_0001};
            9:  return {8'b0001_1100, 8'b0001_1000};
            10: return {8'b0110_0000, 8'b0000_0000};
            default: return {8'b0000_0011, 8'b0000_0010};
        endcase
    endfunction

    task automatic run_instr(input bit sel, input logic [5:0] op,
                             input logic [5:0] fn, input bit z,
                             input int fs, input int ms);
        bit hs, ill, mw;
        int a;
        logic [7:0] obs;
        logic [15:0] me;
        hs = !sel;
        ill = 1'b0;
        q.delete();
        if (hs) begin
            for (int i = 0; i < fs; i++) push(0, 0, 0, 0, 0, 0, 0, 2);
            push(0, 1, 1, 1, 0, 0, 0, 2);
        end else begin
            push(0, 1'($urandom), 1, 1, 0, 0, 0, 2);
        end
        push(1, 1'($urandom), 0, 0, 0, 0, 0, 2);
        mw = hs ? 1'b1 : 1'($urandom);
        if (op == 6'b100011 || op == 6'b101011) begin
            push(2, 1'($urandom), 0, 0, 0, 0, 0, 2);
            if (op == 6'b100011) begin
                if (hs) for (int i = 0; i < ms; i++)
                    push(3, 0, 0, 0, 0, 0, 0, -1);
                push(3, mw, 0, 0, 0, 0, 0, -1);
                push(4, 1'($urandom), 0, 0, 1, 0, 1, -1);
            end else begin
                if (hs) for (int i = 0; i < ms; i++)
                    push(5, 0, 0, 0, 0, 1, 0, -1);
                push(5, mw, 0, 0, 0, 1, 1, -1);
            end
        end else if (op == 6'b000000) begin
            a = alu_of(fn);
            push(6, 1'($urandom), 0, 0, 0, 0, 0, (a < 0) ? 2 : a);
            if (a < 0) ill = 1'b1;
            else push(7, 1'($urandom), 0, 0, 1, 0, 1, -1);
        end else if (op == 6'b000100) begin
            push(8, 1'($urandom), 0, z, 0, 0, 1, 6);
        end else if (op == 6'b001000 && !sel) begin
            push(9, 1'($urandom), 0, 0, 0, 0, 0, 2);
            push(10, 1'($urandom), 0, 0, 1, 0, 1, -1);
        end else if (op == 6'b000010) begin
            push(11, 1'($urandom), 0, 1, 0, 0, 1, -1);
        end else begin
            ill = 1'b1;
        end

        if (sel) begin op2 = op; fn2 = fn; z2 = z; end
        else begin op1 = op; fn1 = fn; z1 = z; end

        for (int i = 0; i < q.size(); i++) begin
            if (sel) mr2 = q[i].mr; else mr1 = q[i].mr;
            @(negedge clk);
            check("state", sel ? st2 : st1, q[i].st);
            check("ir_write", sel ? iw2 : iw1, q[i].irw);
            check("pc_en", sel ? pe2 : pe1, q[i].pcen);
            check("reg_write", sel ? rw2 : rw1, q[i].regw);
            check("mem_write", sel ? mw2 : mw1, q[i].memw);
            check("instr_done", sel ? dn2 : dn1, q[i].done);
            check("illegal_op", sel ? il2 : il1,
                  (i == 0) ? pend[sel] : 1'b0);
            check("retired_cnt", sel ? 32'(cnt2) : 32'(cnt1),
                  cnt_m[sel]);
            if (q[i].alu >= 0)
                check("alu_control", sel ? alu2 : alu1, q[i].alu);
            obs = sel ? {io2, rd2, m2r2, asa2, asb2, ps2}
                      : {io1, rd1, m2r1, asa1, asb1, ps1};
            me = mux_exp(q[i].st);
            check("mux_sel", obs & me[15:8], me[7:0] & me[15:8]);
            if (q[i].done)
                cnt_m[sel] = (cnt_m[sel] + 1) % (sel ? 16 : 65536);
            @(posedge clk);
            #1;
        end
        pend[sel] = ill;
    endtask

    function automatic logic [5:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 6'b100011;
            1: return 6'b101011;
            2: return 6'b000000;
            3: return 6'b000100;
            4: return 6'b001000;
            5: return 6'b000010;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] rnd_fn();
        case ($urandom_range(0, 5))
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            4: return 6'b101010;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic reset_models();
        cnt_m[0] = 0; cnt_m[1] = 0;
        pend[0] = 0; pend[1] = 0;
    endtask

    initial begin
        op1 = 0; fn1 = 0; z1 = 0; mr1 = 1;
        op2 = 6'b111111; fn2 = 0; z2 = 0; mr2 = 1;
        reset_models();
        #12;
        check("rst_state", st1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_ir_write", iw1, 0);
        check("rst_pc_en", pe1, 0);
        check("rst_illegal", il1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(0, 6'b100011, 6'b000000, 0, 2, 2);
        run_instr(0, 6'b000000, 6'b100010, 0, 0, 0);
        run_instr(0, 6'b000100, 6'b000000, 1, 0, 0);
        run_instr(0, 6'b000100, 6'b000000, 0, 1, 0);
        run_instr(0, 6'b111111, 6'b000000, 0, 0, 0);
        run_instr(0, 6'b000000, 6'b111111, 0, 0, 0);
        run_instr(0, 6'b101011, 6'b000000, 0, 0, 3);
        for (int n = 0; n < 60; n++)
            run_instr(0, rnd_op(), rnd_fn(), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));

        // abort an R-type while it is in EXEC
        op1 = 6'b000000; fn1 = 6'b100000; mr1 = 1'b1;
        for (int i = 0; i < 10 && st1 != 4'd6; i++) @(negedge clk);
        check("reach_exec", st1, 6);
        rst_n = 1'b0;
        #1;
        check("arst_state", st1, 0);
        check("arst_cnt", cnt1, 0);
        check("arst_ir_write", iw1, 0);
        check("arst_pc_en", pe1, 0);
        check("arst_reg_write", rw1, 0);
        check("arst_mem_write", mw1, 0);
        check("arst_illegal", il1, 0);
        check("arst_done", dn1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_models();

        run_instr(1, 6'b001000, 6'b000000, 0, 0, 0);
        run_instr(1, 6'b111111, 6'b000000, 0, 0, 0);
        for (int n = 0; n < 17; n++)
            run_instr(1, 6'b000010, 6'b000000, 0, 0, 0);
        check("wrap_cnt", cnt2, 1);
        for (int n = 0; n < 60; n++)
            run_instr(1, rnd_op(), rnd_fn(), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
